// File: rtl/accu_pkg.sv
// Shared width helpers and default parameters for the group accumulator
// and its reference bench.
package accu_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_GROUP_N = 4;

   function automatic int accu_cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // A sum of n samples of data_w bits never exceeds data_w + clog2(n+1) bits.
   function automatic int accu_out_w(input int data_w, input int n);
      return data_w + $clog2(n + 1);
   endfunction

endpackage

// File: rtl/accu_out_slot.sv
// One-entry valid/ready holding register for a group sum and its beat count.
module accu_out_slot
   import accu_pkg::*;
#(
   parameter int SUM_W  = accu_out_w(DEF_DATA_W, DEF_GROUP_N),
   parameter int BEAT_W = accu_cnt_w(DEF_GROUP_N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [SUM_W-1:0]  load_data,
   input  logic [BEAT_W-1:0] load_beats,
   input  logic              ready_out,
   output logic [SUM_W-1:0]  data_out,
   output logic [BEAT_W-1:0] beats_out,
   output logic              valid_out,
   output logic              slot_free
);

   assign slot_free = !valid_out | ready_out;

   // A load in the draining cycle keeps valid_out high without a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out  <= '0;
         beats_out <= '0;
         valid_out <= 1'b0;
      end else if (load) begin
         data_out  <= load_data;
         beats_out <= load_beats;
         valid_out <= 1'b1;
      end else if (valid_out && ready_out) begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: rtl/accu_group.sv
// Group accumulator: sums every GROUP_N accepted samples (or fewer on flush)
// and hands each sum to a held output slot.
module accu_group
   import accu_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int GROUP_N = DEF_GROUP_N,
   parameter int OUT_W   = accu_out_w(DATA_W, GROUP_N),
   parameter int CNT_W   = accu_cnt_w(GROUP_N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_in,
   input  logic              flush,
   output logic [OUT_W-1:0]  data_out,
   output logic [CNT_W-1:0]  beats_out,
   output logic              valid_out,
   input  logic              ready_out
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUP_N - 1);

   logic [OUT_W-1:0] acc_reg, acc_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [OUT_W-1:0] sample;
   logic [OUT_W-1:0] sum;
   logic [CNT_W-1:0] beats;
   logic             slot_free;
   logic             at_last;
   logic             in_fire;
   logic             close;

   assign sample  = {{(OUT_W-DATA_W){1'b0}}, data_in};
   assign at_last = (cnt_reg == LAST);

   // Only the completing beat has to wait for room in the output slot.
   assign ready_in = slot_free | !at_last;
   assign in_fire  = valid_in & ready_in;
   assign close    = (in_fire & at_last)
                   | (flush & slot_free & ((cnt_reg != '0) | in_fire));

   assign sum   = acc_reg + (in_fire ? sample : '0);
   assign beats = cnt_reg + CNT_W'(in_fire);

   always_comb begin
      acc_next = acc_reg;
      cnt_next = cnt_reg;
      if (close) begin
         acc_next = '0;
         cnt_next = '0;
      end else if (in_fire) begin
         acc_next = sum;
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg <= '0;
         cnt_reg <= '0;
      end else begin
         acc_reg <= acc_next;
         cnt_reg <= cnt_next;
      end
   end

   accu_out_slot #(
      .SUM_W  (OUT_W),
      .BEAT_W (CNT_W)
   ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (close),
      .load_data  (sum),
      .load_beats (beats),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .beats_out  (beats_out),
      .valid_out  (valid_out),
      .slot_free  (slot_free)
   );

endmodule
